// File: rtl/tx_request_latch_pkg.sv
// Shared types and default lookup tables for the front-panel TX request block.
package tx_request_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_PEND = 2'd2,
        ST_HELD = 2'd3
    } state_e;

    localparam int unsigned BYTES_DEF [4] = '{32'd1, 32'd32, 32'd128, 32'd256};
    localparam int unsigned DISP_DEF  [4] = '{32'd0, 32'd5, 32'd10, 32'd20};

endpackage

// File: rtl/tx_request_latch_stable_tick_counter.sv
// Counts consecutive ce samples at LEVEL, saturating at TARGET. done_o flags the
// sample that completes the run, so the caller can act on that very edge.
module stable_tick_counter #(
    parameter int unsigned TARGET = 64,
    parameter logic        LEVEL  = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ce_i,
    input  logic level_i,
    input  logic clr_i,
    output logic done_o
);

    localparam int unsigned CW = $clog2(TARGET + 1);
    localparam logic [CW-1:0] TARGET_C = CW'(TARGET);
    localparam logic [CW-1:0] LAST_C   = CW'(TARGET - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (ce_i) begin
            if (level_i != LEVEL) begin
                count_d = '0;
            end else if (count_q != TARGET_C) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = ce_i && !clr_i && (level_i == LEVEL) && (count_q == LAST_C);

endmodule

// File: rtl/tx_request_latch.sv
// Debounced button request: snapshots settings and issues one start strobe per
// accepted press (or auto-repeat), interlocked with the transmitter busy flag.
module tx_request_latch
    import tx_request_pkg::*;
#(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned CNT_W          = 15,
    parameter int unsigned DISP_W         = 8,
    parameter int unsigned DEBOUNCE_TICKS = 64,
    parameter int unsigned REPEAT_TICKS   = 3200,
    parameter int unsigned BYTES_0        = BYTES_DEF[0],
    parameter int unsigned BYTES_1        = BYTES_DEF[1],
    parameter int unsigned BYTES_2        = BYTES_DEF[2],
    parameter int unsigned BYTES_3        = BYTES_DEF[3],
    parameter int unsigned DISP_0         = DISP_DEF[0],
    parameter int unsigned DISP_1         = DISP_DEF[1],
    parameter int unsigned DISP_2         = DISP_DEF[2],
    parameter int unsigned DISP_3         = DISP_DEF[3]
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              button,
    input  logic              repeat_en,
    input  logic              tx_busy,
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        delay_sel,
    input  logic [1:0]        bytes_sel,
    output logic              start_pulse,
    output logic [DATA_W-1:0] data_latch,
    output logic [1:0]        delay_latch,
    output logic [DISP_W-1:0] delay_disp,
    output logic [CNT_W-1:0]  bytes_to_send,
    output logic [7:0]        fire_count,
    output logic              pending
);

    localparam int unsigned RW = $clog2(REPEAT_TICKS + 1);
    localparam logic [RW-1:0] REP_LAST_C = RW'(REPEAT_TICKS - 1);

    state_e            state_q, state_d;
    logic              start_q, start_d;
    logic [7:0]        fire_q, fire_d;
    logic [RW-1:0]     rep_q, rep_d;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        delay_q;
    logic [DISP_W-1:0] disp_q;
    logic [CNT_W-1:0]  bytes_q;
    logic              capture;
    logic              press_done, release_done, rep_wrap;

    function automatic logic [CNT_W-1:0] bytes_lookup(input logic [1:0] sel);
        case (sel)
            2'd0:    bytes_lookup = CNT_W'(BYTES_0);
            2'd1:    bytes_lookup = CNT_W'(BYTES_1);
            2'd2:    bytes_lookup = CNT_W'(BYTES_2);
            default: bytes_lookup = CNT_W'(BYTES_3);
        endcase
    endfunction

    function automatic logic [DISP_W-1:0] disp_lookup(input logic [1:0] sel);
        case (sel)
            2'd0:    disp_lookup = DISP_W'(DISP_0);
            2'd1:    disp_lookup = DISP_W'(DISP_1);
            2'd2:    disp_lookup = DISP_W'(DISP_2);
            default: disp_lookup = DISP_W'(DISP_3);
        endcase
    endfunction

    // Press run is only meaningful while idle/arming; release run only while held.
    stable_tick_counter #(.TARGET(DEBOUNCE_TICKS), .LEVEL(1'b1)) u_press (
        .clk     (clk),
        .reset_n (reset_n),
        .ce_i    (ce),
        .level_i (button),
        .clr_i   ((state_q == ST_PEND) || (state_q == ST_HELD)),
        .done_o  (press_done)
    );

    stable_tick_counter #(.TARGET(DEBOUNCE_TICKS), .LEVEL(1'b0)) u_release (
        .clk     (clk),
        .reset_n (reset_n),
        .ce_i    (ce),
        .level_i (button),
        .clr_i   (state_q != ST_HELD),
        .done_o  (release_done)
    );

    assign rep_wrap = ce && (rep_q == REP_LAST_C);

    always_comb begin
        rep_d = '0;
        if (state_q == ST_HELD) begin
            rep_d = rep_q;
            if (ce) begin
                rep_d = rep_wrap ? '0 : rep_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        fire_d  = fire_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ce && button) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (press_done) begin
                    state_d = ST_PEND;
                    capture = 1'b1;
                end else if (ce && !button) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (!tx_busy) begin
                    start_d = 1'b1;
                    fire_d  = fire_q + 8'd1;
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                // Release takes priority over a coincident repeat fire.
                if (release_done) begin
                    state_d = ST_IDLE;
                end else if (rep_wrap && repeat_en && button) begin
                    state_d = ST_PEND;
                    capture = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            fire_q  <= '0;
            rep_q   <= '0;
            data_q  <= '0;
            delay_q <= '0;
            disp_q  <= '0;
            bytes_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            fire_q  <= fire_d;
            rep_q   <= rep_d;
            if (capture) begin
                data_q  <= data;
                delay_q <= delay_sel;
                disp_q  <= disp_lookup(delay_sel);
                bytes_q <= bytes_lookup(bytes_sel);
            end
        end
    end

    assign start_pulse   = start_q;
    assign data_latch    = data_q;
    assign delay_latch   = delay_q;
    assign delay_disp    = disp_q;
    assign bytes_to_send = bytes_q;
    assign fire_count    = fire_q;
    assign pending       = (state_q == ST_PEND);

endmodule

// File: tb/tb_tx_request_latch.sv
// Scoreboard bench for tx_request_latch: expected snapshots are queued when a
// press is driven and matched against what the DUT shows on each start pulse.
module tb_tx_request_latch;

    localparam int DEB = 4;
    localparam int REP = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce = 1'b0;
    logic       button = 1'b0;
    logic       repeat_en = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] data = 8'h00;
    logic [1:0] delay_sel = 2'd0;
    logic [1:0] bytes_sel = 2'd0;

    logic        start_pulse;
    logic [7:0]  data_latch;
    logic [1:0]  delay_latch;
    logic [7:0]  delay_disp;
    logic [14:0] bytes_to_send;
    logic [7:0]  fire_count;
    logic        pending;

    typedef struct packed {
        logic [7:0]  d;
        logic [1:0]  dl;
        logic [7:0]  disp;
        logic [14:0] bytes;
        logic [7:0]  fc;
        logic        busy;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   pulse_cnt = 0;
    int   fire_exp = 0;
    int unsigned disp_tab [4] = '{0, 5, 10, 20};
    int unsigned bytes_tab[4] = '{1, 32, 128, 256};

    tx_request_latch #(
        .DEBOUNCE_TICKS (DEB),
        .REPEAT_TICKS   (REP)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ce            (ce),
        .button        (button),
        .repeat_en     (repeat_en),
        .tx_busy       (tx_busy),
        .data          (data),
        .delay_sel     (delay_sel),
        .bytes_sel     (bytes_sel),
        .start_pulse   (start_pulse),
        .data_latch    (data_latch),
        .delay_latch   (delay_latch),
        .delay_disp    (delay_disp),
        .bytes_to_send (bytes_to_send),
        .fire_count    (fire_count),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n && start_pulse === 1'b1) begin
            obs_q.push_back('{data_latch, delay_latch, delay_disp, bytes_to_send, fire_count, tx_busy});
            pulse_cnt++;
        end
    end

    task automatic push_exp();
        fire_exp = (fire_exp + 1) % 256;
        exp_q.push_back('{data, delay_sel, 8'(disp_tab[delay_sel]), 15'(bytes_tab[bytes_sel]),
                          8'(fire_exp), 1'b0});
        $display("expect: data=%h dly=%0d disp=%0d bytes=%0d fire=%0d",
                 data, delay_sel, disp_tab[delay_sel], bytes_tab[bytes_sel], fire_exp);
    endtask

    // One ce sample of level b, then three idle clocks; entered #1 after a posedge.
    task automatic sample(input logic b);
        button = b;
        ce = 1'b1;
        @(posedge clk); #1;
        ce = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({start_pulse, data_latch, delay_latch, delay_disp, bytes_to_send} !== '0) begin
            n_err++;
            $display("FAIL reset_latches: got %h want 0",
                     {start_pulse, data_latch, delay_latch, delay_disp, bytes_to_send});
        end
        n_cmp++;
        if (fire_count !== 8'd0 || pending !== 1'b0) begin
            n_err++;
            $display("FAIL reset_counters: fire_count=%0d pending=%b want 0/0", fire_count, pending);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        $display("reset: fire_count=%0d pending=%b", fire_count, pending);
    endtask

    task automatic test_single_press();
        rec_t o, e;
        int p0 = pulse_cnt;
        repeat_en = 1'b0; tx_busy = 1'b0;
        data = 8'h5A; delay_sel = 2'd2; bytes_sel = 2'd1;
        push_exp();
        repeat (DEB - 1) sample(1'b1);
        n_cmp++;
        if (pulse_cnt !== p0 || pending !== 1'b0) begin
            n_err++;
            $display("FAIL single_early: pulses=%0d pending=%b want %0d/0", pulse_cnt - p0, pending, 0);
        end
        sample(1'b1);
        n_cmp++;
        if (pulse_cnt !== p0 + 1) begin
            n_err++;
            $display("FAIL single_pulse: pulses=%0d want 1", pulse_cnt - p0);
        end
        n_cmp++;
        if (data_latch !== 8'h5A || delay_disp !== 8'd10 || bytes_to_send !== 15'd32 || fire_count !== 8'd1) begin
            n_err++;
            $display("FAIL single_latch: data=%h disp=%0d bytes=%0d fire=%0d want 5a/10/32/1",
                     data_latch, delay_disp, bytes_to_send, fire_count);
        end
        repeat (DEB) sample(1'b0);
        while (obs_q.size() != 0) begin
            o = obs_q.pop_front(); n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL single_sb_extra: got %h want none", o); end
            else begin e = exp_q.pop_front(); if (o !== e) begin n_err++; $display("FAIL single_sb: got %h want %h", o, e); end end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL single_sb_missing: got %0d outstanding want 0", exp_q.size()); exp_q.delete(); end
        $display("single_press: pulses=%0d fire_count=%0d", pulse_cnt - p0, fire_count);
    endtask

    task automatic test_bounce();
        rec_t o, e;
        int p0 = pulse_cnt;
        data = 8'h33; delay_sel = 2'd0; bytes_sel = 2'd0;
        push_exp();
        repeat (DEB - 1) sample(1'b1);
        sample(1'b0);
        n_cmp++;
        if (pulse_cnt !== p0) begin n_err++; $display("FAIL bounce_first: pulses=%0d want 0", pulse_cnt - p0); end
        repeat (DEB - 1) sample(1'b1);
        n_cmp++;
        if (pulse_cnt !== p0 || pending !== 1'b0) begin
            n_err++; $display("FAIL bounce_partial: pulses=%0d pending=%b want 0/0", pulse_cnt - p0, pending);
        end
        sample(1'b1);
        n_cmp++;
        if (pulse_cnt !== p0 + 1) begin n_err++; $display("FAIL bounce_pulse: pulses=%0d want 1", pulse_cnt - p0); end
        repeat (DEB) sample(1'b0);
        while (obs_q.size() != 0) begin
            o = obs_q.pop_front(); n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL bounce_sb_extra: got %h want none", o); end
            else begin e = exp_q.pop_front(); if (o !== e) begin n_err++; $display("FAIL bounce_sb: got %h want %h", o, e); end end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL bounce_sb_missing: got %0d outstanding want 0", exp_q.size()); exp_q.delete(); end
        $display("bounce: pulses=%0d fire_count=%0d", pulse_cnt - p0, fire_count);
    endtask

    task automatic test_busy();
        rec_t o, e;
        int p0 = pulse_cnt;
        int bad = 0;
        tx_busy = 1'b1;
        data = 8'hC3; delay_sel = 2'd3; bytes_sel = 2'd3;
        push_exp();
        repeat (DEB - 1) sample(1'b1);
        button = 1'b1; ce = 1'b1;
        @(posedge clk); #1;
        ce = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (pending !== 1'b1 || start_pulse !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (bad != 0 || pulse_cnt !== p0) begin
            n_err++; $display("FAIL busy_hold: bad_cycles=%0d pulses=%0d want 0/0", bad, pulse_cnt - p0);
        end
        tx_busy = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (start_pulse !== 1'b1 || pending !== 1'b0) begin
            n_err++; $display("FAIL busy_release: start=%b pending=%b want 1/0", start_pulse, pending);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (start_pulse !== 1'b0) begin n_err++; $display("FAIL busy_width: start=%b want 0", start_pulse); end
        repeat (DEB) sample(1'b0);
        n_cmp++;
        if (pulse_cnt !== p0 + 1) begin n_err++; $display("FAIL busy_count: pulses=%0d want 1", pulse_cnt - p0); end
        while (obs_q.size() != 0) begin
            o = obs_q.pop_front(); n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL busy_sb_extra: got %h want none", o); end
            else begin e = exp_q.pop_front(); if (o !== e) begin n_err++; $display("FAIL busy_sb: got %h want %h", o, e); end end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL busy_sb_missing: got %0d outstanding want 0", exp_q.size()); exp_q.delete(); end
        $display("busy: pulses=%0d fire_count=%0d", pulse_cnt - p0, fire_count);
    endtask

    task automatic test_hold_no_repeat();
        rec_t o, e;
        int p0 = pulse_cnt;
        repeat_en = 1'b0;
        data = 8'h11; delay_sel = 2'd1; bytes_sel = 2'd0;
        push_exp();
        repeat (10 * REP) sample(1'b1);
        n_cmp++;
        if (pulse_cnt !== p0 + 1) begin n_err++; $display("FAIL hold_single: pulses=%0d want 1", pulse_cnt - p0); end
        repeat (DEB) sample(1'b0);
        data = 8'h22; delay_sel = 2'd0; bytes_sel = 2'd2;
        push_exp();
        repeat (DEB) sample(1'b1);
        n_cmp++;
        if (pulse_cnt !== p0 + 2 || fire_count !== 8'(fire_exp)) begin
            n_err++; $display("FAIL hold_repress: pulses=%0d fire=%0d want 2/%0d", pulse_cnt - p0, fire_count, fire_exp);
        end
        repeat (DEB) sample(1'b0);
        while (obs_q.size() != 0) begin
            o = obs_q.pop_front(); n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL hold_sb_extra: got %h want none", o); end
            else begin e = exp_q.pop_front(); if (o !== e) begin n_err++; $display("FAIL hold_sb: got %h want %h", o, e); end end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL hold_sb_missing: got %0d outstanding want 0", exp_q.size()); exp_q.delete(); end
        $display("hold_no_repeat: pulses=%0d fire_count=%0d", pulse_cnt - p0, fire_count);
    endtask

    task automatic test_auto_repeat();
        rec_t o, e;
        int p0 = pulse_cnt;
        logic [1:0] blk;
        repeat_en = 1'b1;
        data = 8'h40; delay_sel = 2'd2; bytes_sel = 2'd2;
        push_exp();
        repeat (DEB) sample(1'b1);
        for (int j = 0; j < 30; j++) begin
            if (j % REP == 0 && j < 24) begin
                blk = 2'(j / REP);
                data = 8'h41 + 8'(blk);
                delay_sel = blk;
                bytes_sel = blk;
                push_exp();
            end
            sample(1'b1);
        end
        n_cmp++;
        if (pulse_cnt !== p0 + 4) begin n_err++; $display("FAIL repeat_count: pulses=%0d want 4", pulse_cnt - p0); end
        repeat (DEB) sample(1'b0);
        repeat_en = 1'b0;
        n_cmp++;
        if (pulse_cnt !== p0 + 4 || pending !== 1'b0) begin
            n_err++; $display("FAIL repeat_release: pulses=%0d pending=%b want 4/0", pulse_cnt - p0, pending);
        end
        while (obs_q.size() != 0) begin
            o = obs_q.pop_front(); n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL repeat_sb_extra: got %h want none", o); end
            else begin e = exp_q.pop_front(); if (o !== e) begin n_err++; $display("FAIL repeat_sb: got %h want %h", o, e); end end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL repeat_sb_missing: got %0d outstanding want 0", exp_q.size()); exp_q.delete(); end
        $display("auto_repeat: pulses=%0d fire_count=%0d", pulse_cnt - p0, fire_count);
    endtask

    task automatic test_reset_in_pend();
        int p0 = pulse_cnt;
        tx_busy = 1'b1;
        data = 8'h77; delay_sel = 2'd1; bytes_sel = 2'd3;
        repeat (DEB) sample(1'b1);
        n_cmp++;
        if (pending !== 1'b1) begin n_err++; $display("FAIL rstpend_enter: pending=%b want 1", pending); end
        button = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({start_pulse, data_latch, delay_latch, delay_disp, bytes_to_send, fire_count, pending} !== '0) begin
            n_err++;
            $display("FAIL rstpend_outputs: got %h want 0",
                     {start_pulse, data_latch, delay_latch, delay_disp, bytes_to_send, fire_count, pending});
        end
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        tx_busy = 1'b0;
        repeat (6) sample(1'b0);
        n_cmp++;
        if (pulse_cnt !== p0 || fire_count !== 8'd0 || pending !== 1'b0) begin
            n_err++;
            $display("FAIL rstpend_after: pulses=%0d fire=%0d pending=%b want 0/0/0", pulse_cnt - p0, fire_count, pending);
        end
        n_cmp++;
        if (obs_q.size() != 0) begin n_err++; $display("FAIL rstpend_sb_extra: got %0d pulses want 0", obs_q.size()); obs_q.delete(); end
        $display("reset_in_pend: pulses=%0d fire_count=%0d", pulse_cnt - p0, fire_count);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_single_press();
        test_bounce();
        test_busy();
        test_hold_no_repeat();
        test_auto_repeat();
        test_reset_in_pend();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
